// File: rtl/mon_ram_reader.sv
// mon_ram_reader: read-side burst engine for the monitor's 2K x 18 block RAM.
// Accepts a start command (base address + word count), issues sequential
// synchronous reads and streams the returned words out on a valid/ready port.
//
// Ports:
//   clk, rst_x             clock, asynchronous active-low reset
//   start/base_addr/len    command strobe, first address, word count (clamped)
//   busy, done             burst in progress, 1-cycle completion pulse
//   ram_ce/ram_we/ram_addr RAM control (active-low enables), ram_do read data
//   dout/dout_vld/dout_rdy output stream
//
// The read pipeline has two stages: the issue stage (ram_ce low) and the data
// stage (ram_do valid, tracked by rd_vld). Words land in a 2-entry buffer whose
// head register drives dout. When the buffer is full the data-stage word is
// left parked on ram_do, which the RAM holds while ram_ce stays high; the issue
// rule only lets a read go out if the parked word is guaranteed a buffer slot
// before the RAM output is overwritten.
module mon_ram_reader #(
  parameter int unsigned AW = 11,
  parameter int unsigned DW = 18,
  parameter int unsigned LW = 12
) (
  input  logic          clk,
  input  logic          rst_x,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic [LW-1:0] len,
  output logic          busy,
  output logic          done,
  output logic          ram_ce,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  input  logic [DW-1:0] ram_do,
  output logic [DW-1:0] dout,
  output logic          dout_vld,
  input  logic          dout_rdy
);

  localparam int unsigned MAX_LEN = 1 << AW;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]    state, state_nxt;
  logic [AW-1:0] addr, addr_nxt;
  logic [LW-1:0] remaining, rem_nxt;
  logic          rd_vld, rd_vld_nxt;
  logic [DW-1:0] tail, tail_nxt;
  logic          tail_vld, tail_vld_nxt;
  logic          busy_nxt, done_nxt, ram_ce_nxt;
  logic [AW-1:0] ram_addr_nxt;
  logic [DW-1:0] dout_nxt;
  logic          dout_vld_nxt;

  logic          pop, cap, room, issue;
  logic [1:0]    occ, occ_after;
  logic [LW-1:0] len_eff;

  assign ram_we  = 1'b1;
  assign len_eff = (len > LW'(MAX_LEN)) ? LW'(MAX_LEN) : len;

  // State and output registers
  always_ff @(posedge clk or negedge rst_x) begin
    if (!rst_x) begin
      state     <= S_IDLE;
      addr      <= '0;
      remaining <= '0;
      rd_vld    <= 1'b0;
      tail      <= '0;
      tail_vld  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      ram_ce    <= 1'b1;
      ram_addr  <= '0;
      dout      <= '0;
      dout_vld  <= 1'b0;
    end else begin
      state     <= state_nxt;
      addr      <= addr_nxt;
      remaining <= rem_nxt;
      rd_vld    <= rd_vld_nxt;
      tail      <= tail_nxt;
      tail_vld  <= tail_vld_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
      ram_ce    <= ram_ce_nxt;
      ram_addr  <= ram_addr_nxt;
      dout      <= dout_nxt;
      dout_vld  <= dout_vld_nxt;
    end
  end

  // Next-state, buffer and read-issue logic
  always_comb begin
    state_nxt    = state;
    addr_nxt     = addr;
    rem_nxt      = remaining;
    busy_nxt     = busy;
    done_nxt     = 1'b0;
    ram_addr_nxt = ram_addr;
    issue        = 1'b0;

    // Buffer occupancy after this cycle's pop, then capture if a slot is free
    pop       = dout_vld & dout_rdy;
    occ       = 2'(dout_vld) + 2'(tail_vld) - 2'(pop);
    cap       = rd_vld & (occ < 2'd2);
    occ_after = occ + 2'(cap);

    // The issue-stage read becomes next cycle's data-stage word; an uncaptured
    // data-stage word stays parked on ram_do
    rd_vld_nxt = ~ram_ce | (rd_vld & ~cap);

    // A new read is safe if next cycle's data-stage word can be captured even
    // with no pop, so the RAM output is never overwritten while parked
    room = ~rd_vld_nxt | (occ_after < 2'd2);

    // Head/tail shift buffer: pop shifts tail to head, capture fills first gap
    dout_vld_nxt = dout_vld;
    dout_nxt     = dout;
    tail_vld_nxt = tail_vld;
    tail_nxt     = tail;
    if (pop) begin
      dout_vld_nxt = tail_vld;
      if (tail_vld) dout_nxt = tail;
      tail_vld_nxt = 1'b0;
    end
    if (cap) begin
      if (!dout_vld_nxt) begin
        dout_vld_nxt = 1'b1;
        dout_nxt     = ram_do;
      end else begin
        tail_vld_nxt = 1'b1;
        tail_nxt     = ram_do;
      end
    end

    case (state)
      S_IDLE: begin
        if (start) begin
          if (len_eff == '0) begin
            done_nxt = 1'b1;
          end else begin
            // Pipeline is empty in IDLE, so the first read goes out at once
            issue        = 1'b1;
            ram_addr_nxt = base_addr;
            addr_nxt     = base_addr + AW'(1);
            rem_nxt      = len_eff - LW'(1);
            busy_nxt     = 1'b1;
            state_nxt    = (len_eff == LW'(1)) ? S_DRAIN : S_RUN;
          end
        end
      end
      S_RUN: begin
        if (room) begin
          issue        = 1'b1;
          ram_addr_nxt = addr;
          addr_nxt     = addr + AW'(1);
          rem_nxt      = remaining - LW'(1);
          if (remaining == LW'(1)) state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (!dout_vld && !tail_vld && ram_ce && !rd_vld) begin
          state_nxt = S_IDLE;
          busy_nxt  = 1'b0;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase

    ram_ce_nxt = ~issue;
  end

endmodule

// File: tb/tb_mon_ram_reader.sv
// Self-checking bench for mon_ram_reader: table of bursts plus hand-written
// sequences for a start pulsed mid-burst and a reset mid-burst.
module tb_mon_ram_reader;

  localparam int unsigned AW = 11;
  localparam int unsigned DW = 18;
  localparam int unsigned LW = 12;

  logic          clk = 1'b0;
  logic          rst_x;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [LW-1:0] len;
  logic          busy, done;
  logic          ram_ce, ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_do;
  logic [DW-1:0] dout;
  logic          dout_vld;
  logic          dout_rdy;

  mon_ram_reader #(.AW(AW), .DW(DW), .LW(LW)) dut (
    .clk(clk), .rst_x(rst_x), .start(start), .base_addr(base_addr), .len(len),
    .busy(busy), .done(done), .ram_ce(ram_ce), .ram_we(ram_we),
    .ram_addr(ram_addr), .ram_do(ram_do), .dout(dout), .dout_vld(dout_vld),
    .dout_rdy(dout_rdy)
  );

  always #5 clk = ~clk;

  // Synchronous-read RAM; output register holds its value while ram_ce is high
  logic [DW-1:0] ram [0:2047];
  always @(posedge clk) begin
    if (!ram_ce) ram_do <= ram[ram_addr];
  end

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  logic [DW-1:0] got_q [$];
  logic [AW-1:0] acc_q [$];
  int done_k, done_cnt, first_k, stab_err;
  logic busy_k1;

  // Drives one command and observes until a few cycles past done.
  // k counts rising edges after the edge that samples start.
  // mode 0: ready always 1; 1: ready 1,0,0 repeating; 2: ready 0 until k=10.
  task automatic run_burst(input logic [AW-1:0] b, input logic [LW-1:0] l,
                           input int mode, input int ign_k);
    logic          prev_hold;
    logic [DW-1:0] prev_d;
    got_q.delete();
    acc_q.delete();
    done_k = -1; done_cnt = 0; first_k = -1; stab_err = 0; busy_k1 = 1'b0;
    prev_hold = 1'b0; prev_d = '0;
    @(negedge clk);
    base_addr = b; len = l; start = 1'b1; dout_rdy = (mode != 2);
    for (int k = 0; k < 5000; k++) begin
      @(negedge clk);
      start = (k == ign_k);
      if (k == ign_k) begin
        base_addr = b + AW'(256);
        len       = LW'(3);
      end
      case (mode)
        0:       dout_rdy = 1'b1;
        1:       dout_rdy = (k % 3 == 0);
        default: dout_rdy = (k >= 10);
      endcase
      if (prev_hold && (dout !== prev_d || dout_vld !== 1'b1)) stab_err++;
      prev_hold = dout_vld && !dout_rdy;
      prev_d    = dout;
      if (dout_vld && first_k < 0) first_k = k;
      if (dout_vld && dout_rdy) got_q.push_back(dout);
      if (!ram_ce) acc_q.push_back(ram_addr);
      if (k == 1) busy_k1 = busy;
      if (done) begin
        done_cnt++;
        if (done_k < 0) done_k = k;
      end
      if (done_k >= 0 && k >= done_k + 3) break;
    end
    start = 1'b0;
  endtask

  task automatic verify(input int id, input logic [AW-1:0] b, input int exp_n,
                        input int exp_done, input int exp_fk,
                        input logic [DW-1:0] exp_first, input logic [DW-1:0] exp_last);
    int bad_d, bad_a;
    bad_d = 0; bad_a = 0;
    check($sformatf("v%0d word_count", id), got_q.size(), exp_n);
    check($sformatf("v%0d ram_access_count", id), acc_q.size(), exp_n);
    check($sformatf("v%0d done_pulses", id), done_cnt, 1);
    check($sformatf("v%0d hold_stable", id), stab_err, 0);
    check($sformatf("v%0d busy_after_start", id), busy_k1, exp_n != 0);
    check($sformatf("v%0d busy_after_done", id), busy, 1'b0);
    for (int j = 0; j < got_q.size(); j++)
      if (got_q[j] !== ram[(int'(b) + j) % 2048]) bad_d++;
    for (int j = 0; j < acc_q.size(); j++)
      if (acc_q[j] !== AW'(int'(b) + j)) bad_a++;
    check($sformatf("v%0d data_order", id), bad_d, 0);
    check($sformatf("v%0d addr_sequence", id), bad_a, 0);
    if (exp_done >= 0) check($sformatf("v%0d done_latency", id), done_k, exp_done);
    if (exp_fk >= 0) check($sformatf("v%0d first_vld_latency", id), first_k, exp_fk);
    if (exp_n > 0 && got_q.size() > 0) begin
      check($sformatf("v%0d first_word", id), got_q[0], exp_first);
      check($sformatf("v%0d last_word", id), got_q[got_q.size()-1], exp_last);
    end
  endtask

  typedef struct {
    logic [AW-1:0] base;
    logic [LW-1:0] len;
    int            mode;
    int            exp_n;
    int            exp_done;
    int            exp_fk;
    logic [DW-1:0] first;
    logic [DW-1:0] last;
  } vec_t;

  vec_t vecs [7];

  initial begin
    int cnt;
    for (int i = 0; i < 2048; i++) ram[i] = DW'(i);
    ram[5] = 18'h2A5A5;

    //        base      len        mode n     done  fk  first      last
    vecs[0] = '{11'h005, 12'd1,    0,   1,    4,    2,  18'h2A5A5, 18'h2A5A5};
    vecs[1] = '{11'h100, 12'd8,    0,   8,    11,   2,  18'h00100, 18'h00107};
    vecs[2] = '{11'h100, 12'd8,    1,   8,    -1,   2,  18'h00100, 18'h00107};
    vecs[3] = '{11'h7FE, 12'd4,    0,   4,    7,    2,  18'h007FE, 18'h00001};
    vecs[4] = '{11'h000, 12'd0,    0,   0,    0,    -1, 18'h00000, 18'h00000};
    vecs[5] = '{11'h010, 12'd4000, 0,   2048, 2051, 2,  18'h00010, 18'h0000F};
    vecs[6] = '{11'h300, 12'd5,    2,   5,    -1,   2,  18'h00300, 18'h00304};

    rst_x = 1'b0; start = 1'b0; base_addr = '0; len = '0; dout_rdy = 1'b1;
    repeat (2) @(negedge clk);
    check("reset busy", busy, 1'b0);
    check("reset done", done, 1'b0);
    check("reset ram_ce", ram_ce, 1'b1);
    check("reset ram_we", ram_we, 1'b1);
    check("reset ram_addr", ram_addr, 0);
    check("reset dout", dout, 0);
    check("reset dout_vld", dout_vld, 1'b0);
    rst_x = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      run_burst(vecs[i].base, vecs[i].len, vecs[i].mode, -1);
      verify(i, vecs[i].base, vecs[i].exp_n, vecs[i].exp_done, vecs[i].exp_fk,
             vecs[i].first, vecs[i].last);
    end

    // Start pulsed mid-burst must be ignored
    run_burst(11'h200, 12'd6, 0, 3);
    verify(7, 11'h200, 6, 9, 2, 18'h00200, 18'h00205);

    // Reset mid-burst aborts asynchronously
    @(negedge clk);
    base_addr = 11'h400; len = 12'd16; start = 1'b1; dout_rdy = 1'b1;
    cnt = 0;
    for (int k = 0; k < 50 && cnt < 3; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (dout_vld && dout_rdy) cnt++;
    end
    check("rst words_before_reset", cnt, 3);
    @(posedge clk);
    #2 rst_x = 1'b0;
    #1;
    check("rst busy", busy, 1'b0);
    check("rst done", done, 1'b0);
    check("rst ram_ce", ram_ce, 1'b1);
    check("rst ram_addr", ram_addr, 0);
    check("rst dout", dout, 0);
    check("rst dout_vld", dout_vld, 1'b0);
    repeat (2) @(negedge clk);
    rst_x = 1'b1;
    @(negedge clk);
    check("rst no_done_after_release", done, 1'b0);
    check("rst idle_after_release", busy, 1'b0);
    run_burst(11'h100, 12'd8, 0, -1);
    verify(8, 11'h100, 8, 11, 2, 18'h00100, 18'h00107);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mon_ram_reader.md
Name: mon_ram_reader

Overview:
- Read-side engine for the monitor's 2K x 18 block RAM.
- Takes a start command with a base address and a word count.
- Issues sequential synchronous reads to the RAM port and streams the returned words out over a valid/ready interface.
- Absorbs the RAM's 1-cycle read latency and downstream back-pressure with a 2-entry output buffer, so no word is ever lost or duplicated.

Parameters:
AW, 11, RAM address width (2048 words)
DW, 18, RAM data width
LW, 12, length field width (max count 2048)

Ports:
clk        input   1    Clock
rst_x      input   1    Reset, asynchronous, active-low
start      input   1    Command strobe, 1-cycle pulse, sampled only in IDLE
base_addr  input   AW   First word address of the burst
len        input   LW   Number of words to read, 0..2048
busy       output  1    High from the cycle after an accepted start until done
done       output  1    1-cycle pulse when the burst has fully drained
ram_ce     output  1    RAM chip enable, 0 = access, idle 1
ram_we     output  1    RAM write enable, 0 = write; tied 1 (read-only)
ram_addr   output  AW   RAM address
ram_do     input   DW   RAM read data, valid the cycle after ram_ce=0
dout       output  DW   Stream data
dout_vld   output  1    Stream valid
dout_rdy   input   1    Stream ready; transfer when dout_vld & dout_rdy

Behaviour:
- Reset values (asynchronous on rst_x=0):
  - busy=0, done=0, ram_ce=1, ram_we=1, ram_addr=0, dout=0, dout_vld=0.
  - FSM in IDLE; buffer empty; in-flight flag cleared.
- Clock and registering: all state is on the rising edge of clk. ram_ce, ram_addr, dout and dout_vld are registered outputs.
- FSM states: IDLE, RUN, DRAIN.
- IDLE:
  - start=1 with len!=0: load addr=base_addr and remaining=len, set busy, go to RUN.
  - start=1 with len=0: pulse done on the next cycle, busy stays 0, no RAM access.
- RUN:
  - A read is issued in a cycle only when (buffer count + in-flight − pop this cycle) < 2.
  - Issue means: ram_ce=0 for one cycle with ram_addr=addr; then addr <= addr+1 modulo 2048 (2047 wraps to 0), and remaining is decremented.
  - When the last word is issued, go to DRAIN.
- DRAIN:
  - When the buffer is empty and nothing is in flight: go to IDLE, clear busy, pulse done in that same cycle.
- Read capture: ram_do is written into the buffer on the edge following the cycle in which ram_ce=0.
- Buffer:
  - 2-entry FIFO; the head drives dout/dout_vld.
  - Push and pop may occur in the same cycle; count is unchanged in that case.
  - The buffer never overflows, by the credit rule above.
- Latency and throughput:
  - start sampled at edge T0; first ram_ce=0 in cycle T0..T1; data captured at T2; dout_vld=1 after T2 (3 cycles start-to-data).
  - With dout_rdy held at 1, throughput is 1 word per cycle: N words take N+3 cycles from start to done.
- Back-pressure:
  - dout_rdy=0 holds dout and dout_vld stable.
  - At most 2 words are buffered; further reads stall with ram_ce=1.
- Boundary rules:
  - start while busy: ignored, with no effect on addr or remaining.
  - len>2048: clamped to 2048.
  - Reset mid-operation: aborts immediately; buffered words are discarded; no done pulse.
- ram_we is constant 1; the block never writes.

Test Plan:
1. Single word: preload addr 0x005=0x2A5A5; start, base=5, len=1, dout_rdy=1 -> one ram_ce=0 at addr 5; dout=0x2A5A5 with dout_vld for 1 cycle, 3 cycles after start; done pulses; busy falls.
2. Streaming: RAM[i]=i for i=0x100..0x107; base=0x100, len=8, rdy=1 -> 8 consecutive vld cycles with dout 0x100..0x107; done 11 cycles after start.
3. Back-pressure: same as 2, dout_rdy toggled 1,0,0,1,... -> words delivered in order with none lost or duplicated; ram_ce never low while count+in-flight=2; dout stable while rdy=0.
4. Wrap: base=0x7FE, len=4 -> ram_addr sequence 0x7FE, 0x7FF, 0x000, 0x001; 4 words out.
5. Corner commands: len=0 -> done pulse, no ram_ce; start pulsed mid-burst -> ignored, original count delivered.
6. Reset mid-burst: rst_x=0 after 3 words of len=16 -> all outputs at reset values asynchronously; a new start after release runs cleanly.
